// File: rtl/psg_bus_seq.sv
// AY-style host bus to YM2203/SAA1099 timed access sequencer.
// Define PSG_BUS_PEND_EN to queue one access that arrives while a cycle is running.
module psg_bus_seq #(
  parameter int NUM_YM      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 2,
  parameter int YM_SETUP    = 1,
  parameter int YM_PULSE    = 14,
  parameter int SAA_SETUP   = 3,
  parameter int SAA_PULSE   = 6,
  parameter int RECOVERY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aybdir,
  input  logic              aybc2,
  input  logic              aybc1,
  input  logic              aya8,
  input  logic              aya9_n,
  input  logic [7:0]        ayd_i,
  output logic [7:0]        ayd_o,
  output logic              ayd_oe,
  input  logic [7:0]        d_i,
  output logic [7:0]        d_o,
  output logic              d_oe,
  input  logic [1:0]        ym_sel,
  input  logic              ym_stat,
  input  logic              saa_sel,
  output logic              yma0,
  output logic              ymrd_n,
  output logic              ymwr_n,
  output logic [NUM_YM-1:0] ymcs_n,
  output logic              saaa0,
  output logic              saacs_n,
  output logic              saawr_n,
  output logic              cfg_wr,
  output logic [7:0]        cfg_data,
  output logic              busy,
  output logic              overrun
);
  // state | meaning
  // IDLE  | no access running
  // SETUP | address/data setup (SAA: cs already low)
  // PULSE | chip strobe low
  // HOLD  | strobes released, write data still driven
  // RECOV | quiet gap before the next access
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RECOV} state_t;
  typedef enum logic [1:0] {K_WA, K_WD, K_RD} kind_t;

  localparam int SH_LEN = SYNC_STAGES + FILT_LEN - 1;
  localparam logic [4:0] YM_SET_TC  = 5'(YM_SETUP - 1);
  localparam logic [4:0] YM_PUL_TC  = 5'(YM_PULSE - 1);
  localparam logic [4:0] SAA_SET_TC = 5'(SAA_SETUP - 1);
  localparam logic [4:0] SAA_PUL_TC = 5'(SAA_PULSE - 1);
  localparam logic [4:0] REC_TC     = 5'(RECOVERY - 1);

  logic       q, dec_wa, dec_wd, dec_rd;
  logic [2:0] ctl, raw, filt_q, win_one, win_zero, rise;
  logic [SH_LEN-1:0] sh_q [3];

  assign q      = aya8 & ~aya9_n;
  assign ctl    = {aybdir, aybc2, aybc1};
  assign dec_wa = q & ((ctl == 3'b001) | (ctl == 3'b100) | (ctl == 3'b111));
  assign dec_wd = q & (ctl == 3'b110);
  assign dec_rd = q & (ctl == 3'b011);
  assign raw    = {dec_rd, dec_wd, dec_wa};
  assign ayd_oe = dec_rd & ~saa_sel;

  // The window of the last FILT_LEN synchronised samples decides the filter state.
  always_comb begin
    win_one  = '0;
    win_zero = '0;
    for (int c = 0; c < 3; c++) begin
      win_one[c]  = &sh_q[c][SH_LEN-1:SYNC_STAGES-1];
      win_zero[c] = ~|sh_q[c][SH_LEN-1:SYNC_STAGES-1];
    end
  end
  assign rise = win_one & ~filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) sh_q[c] <= '0;
      filt_q <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        sh_q[c] <= {sh_q[c][SH_LEN-2:0], raw[c]};
        if (win_one[c]) filt_q[c] <= 1'b1;
        else if (win_zero[c]) filt_q[c] <= 1'b0;
      end
    end
  end

  logic  start, cfg_start, bad_start, acc_start;
  kind_t kind_new;
  always_comb begin
    start    = |rise;
    kind_new = K_RD;
    if (rise[0]) kind_new = K_WA;
    else if (rise[1]) kind_new = K_WD;
  end
  assign cfg_start = start & (kind_new == K_WA) & (ayd_i[7:4] == 4'hF);
  assign bad_start = start & ~cfg_start & ~saa_sel & ({1'b0, ym_sel} >= 3'(NUM_YM));
  assign acc_start = start & ~cfg_start & ~bad_start & ~((kind_new == K_RD) & saa_sel);

  state_t     state_q, state_nxt;
  logic [4:0] tmr_q, tmr_nxt;
  logic       end_cyc, launch_new, launch, drop, pend_take;
  logic [7:0] l_d;
  kind_t      l_k;
  logic       l_saa, l_yma0;
  logic [1:0] l_ym;
  logic [7:0] wr_q, rd_q, cfg_q;
  kind_t      kind_q;
  logic       saa_q;
  logic [1:0] ym_q;

`ifdef PSG_BUS_PEND_EN
  logic       pend_vld, pend_load, pend_saa, pend_yma0;
  logic [7:0] pend_d;
  kind_t      pend_k;
  logic [1:0] pend_ym;
`endif

  always_comb begin
    end_cyc = ((state_q == HOLD) && (RECOVERY == 0)) || ((state_q == RECOV) && (tmr_q == 5'd0));
`ifdef PSG_BUS_PEND_EN
    pend_take  = pend_vld & end_cyc;
    launch_new = acc_start & ((state_q == IDLE) | (end_cyc & ~pend_vld));
    pend_load  = acc_start & (state_q != IDLE) & ~end_cyc & ~pend_vld;
    drop       = acc_start & ~launch_new & ~pend_load;
`else
    pend_take  = 1'b0;
    launch_new = acc_start & (state_q == IDLE);
    drop       = acc_start & ~launch_new;
`endif
    launch = launch_new | pend_take;
    l_d    = ayd_i;
    l_k    = kind_new;
    l_saa  = saa_sel;
    l_ym   = ym_sel;
    l_yma0 = (kind_new == K_WD) | ((kind_new == K_RD) & ~ym_stat);
`ifdef PSG_BUS_PEND_EN
    if (pend_take) begin
      l_d    = pend_d;
      l_k    = pend_k;
      l_saa  = pend_saa;
      l_ym   = pend_ym;
      l_yma0 = pend_yma0;
    end
`endif
  end

  always_comb begin
    state_nxt = state_q;
    tmr_nxt   = tmr_q;
    case (state_q)
      IDLE: ;
      SETUP: begin
        if (tmr_q == 5'd0) begin
          state_nxt = PULSE;
          tmr_nxt   = saa_q ? SAA_PUL_TC : YM_PUL_TC;
        end else tmr_nxt = tmr_q - 5'd1;
      end
      PULSE: begin
        if (tmr_q == 5'd0) state_nxt = HOLD;
        else tmr_nxt = tmr_q - 5'd1;
      end
      HOLD: begin
        if (end_cyc) state_nxt = IDLE;
        else begin
          state_nxt = RECOV;
          tmr_nxt   = REC_TC;
        end
      end
      RECOV: begin
        if (end_cyc) state_nxt = IDLE;
        else tmr_nxt = tmr_q - 5'd1;
      end
      default: state_nxt = IDLE;
    endcase
    if (launch) begin
      state_nxt = SETUP;
      tmr_nxt   = l_saa ? SAA_SET_TC : YM_SET_TC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      tmr_q   <= tmr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cfg_q   <= '0;
      cfg_wr  <= 1'b0;
      overrun <= 1'b0;
      yma0    <= 1'b0;
      saaa0   <= 1'b0;
      kind_q  <= K_WA;
      saa_q   <= 1'b0;
      ym_q    <= '0;
    end else begin
      cfg_wr <= cfg_start;
      if (cfg_start) begin
        cfg_q   <= ayd_i;
        overrun <= 1'b0;
      end else if (drop | bad_start) overrun <= 1'b1;
      if (launch) begin
        wr_q   <= l_d;
        kind_q <= l_k;
        saa_q  <= l_saa;
        ym_q   <= l_ym;
        yma0   <= l_yma0;
        saaa0  <= (l_k == K_WA);
      end
      if ((state_q == PULSE) && (tmr_q == 5'd0) && (kind_q == K_RD)) rd_q <= d_i;
    end
  end

`ifdef PSG_BUS_PEND_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_d    <= '0;
      pend_k    <= K_WA;
      pend_saa  <= 1'b0;
      pend_ym   <= '0;
      pend_yma0 <= 1'b0;
    end else if (pend_load) begin
      pend_vld  <= 1'b1;
      pend_d    <= ayd_i;
      pend_k    <= kind_new;
      pend_saa  <= saa_sel;
      pend_ym   <= ym_sel;
      pend_yma0 <= (kind_new == K_WD) | ((kind_new == K_RD) & ~ym_stat);
    end else if (pend_take) pend_vld <= 1'b0;
  end
`endif

  always_comb begin
    ymcs_n = '1;
    for (int i = 0; i < NUM_YM; i++)
      if ((state_q == PULSE) && !saa_q && (ym_q == 2'(i))) ymcs_n[i] = 1'b0;
    ymrd_n  = !((state_q == PULSE) && !saa_q && (kind_q == K_RD));
    ymwr_n  = !((state_q == PULSE) && !saa_q && (kind_q != K_RD));
    saacs_n = !(((state_q == SETUP) || (state_q == PULSE)) && saa_q);
    saawr_n = !((state_q == PULSE) && saa_q);
    d_oe    = ((state_q == SETUP) || (state_q == PULSE) || (state_q == HOLD)) && (kind_q != K_RD);
    busy    = (state_q != IDLE);
  end

  assign d_o      = wr_q;
  assign ayd_o    = rd_q;
  assign cfg_data = cfg_q;
endmodule
